stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_pkg.sv | 49 ++++
 rtl/md_busy_cnt.sv | 49 ++++
 rtl/stall_ctrl.sv | 104 ++++++++++
 tb/tb_stall_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline constants for hazard detection and the mult/div busy tracker.
// Tuse/Tnew timing encodings, operand/destination field widths and the
// fixed mult/div latencies live here so decode, hazard and MD logic agree.
package stall_ctrl_pkg;

    // Field widths
    localparam int REG_W  = 5;   // GRF index width
    localparam int TIME_W = 2;   // Tuse / Tnew width
    localparam int CNT_W  = 4;   // mult/div remaining-cycle counter width

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [TIME_W-1:0] stage_time_t;
    typedef logic [CNT_W-1:0]  md_cnt_t;

    // Tuse encoding: 0..2 = cycles until the operand is consumed,
    // TUSE_NONE = operand not read by this instruction.
    localparam stage_time_t TUSE_NONE = 2'd3;

    // Mult/div occupancy in cycles after the start edge
    localparam md_cnt_t MULT_CYC = 4'd5;
    localparam md_cnt_t DIV_CYC  = 4'd10;

    typedef enum logic {
        MD_OP_MULT = 1'b0,
        MD_OP_DIV  = 1'b1
    } md_op_e;

    // A read-after-write hazard exists when a producer further down the
    // pipe targets the same non-$0 register and will not have its result
    // ready by the time the consumer needs it. Since Tnew never exceeds 2,
    // TUSE_NONE can never satisfy tnew > tuse; the explicit check just makes
    // the intent obvious to a reader.
    function automatic logic raw_hazard(
        input reg_idx_t    src,
        input stage_time_t tuse,
        input reg_idx_t    dst,
        input logic        wr,
        input stage_time_t tnew
    );
        return (src != '0) && (src == dst) && wr &&
               (tuse != TUSE_NONE) && (tnew > tuse);
    endfunction

    // Occupancy loaded into the busy counter for a given operation
    function automatic md_cnt_t md_latency(input md_op_e op);
        return (op == MD_OP_DIV) ? DIV_CYC : MULT_CYC;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy tracker: a down-counter loaded with the unit latency when an
// operation issues, reporting busy while nonzero and a one-cycle done strobe
// in the last busy cycle (used as the HI/LO write enable).
module md_busy_cnt
    import stall_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    srst,
    input  logic    start,
    input  md_op_e  op,
    output logic    busy,
    output logic    done,
    output md_cnt_t cnt
);

    md_cnt_t cnt_reg;
    md_cnt_t cnt_next;
    logic    busy_now;

    assign busy_now = (cnt_reg != '0);

    // Next count: load on an accepted start, otherwise count down to zero.
    // A start while busy (including the final busy cycle) is dropped; the
    // decode stage stall keeps that from happening in legal code.
    always_comb begin
        cnt_next = cnt_reg;
        if (start && !busy_now) begin
            cnt_next = md_latency(op);
        end else if (busy_now) begin
            cnt_next = cnt_reg - md_cnt_t'(1);
        end
    end

    // Counter state; reset aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign busy = busy_now;
    // Done marks the last busy cycle; suppressed under reset so an aborted
    // operation never writes HI/LO.
    assign done = (cnt_reg == md_cnt_t'(1)) && !srst;
    assign cnt  = cnt_reg;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: detects RAW hazards between the instruction in
// D and the producers in E/M using Tuse/Tnew timing, stalls MD-class
// instructions while the mult/div unit is occupied, and drives the PC / D_REG
// enables plus the E_REG bubble. The hazard path is purely combinational.
module stall_ctrl
    import stall_ctrl_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_IsMD,
    input  logic [4:0]  E_RFA3,
    input  logic [4:0]  M_RFA3,
    input  logic        E_RFWr,
    input  logic        M_RFWr,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        E_MDStart,
    input  logic        E_MDOp,
    output logic        F_PC_En,
    output logic        D_REG_We,
    output logic        E_REG_Clr,
    output logic        MD_Busy,
    output logic        MD_Done,
    output logic [3:0]  MD_Cnt
);

    localparam int N_SRC  = 2;  // rs, rt
    localparam int N_PROD = 2;  // E, M

    // Consumer operands (index 0 = rs, 1 = rt)
    reg_idx_t    src_reg  [N_SRC];
    stage_time_t src_tuse [N_SRC];
    // Producers (index 0 = E, 1 = M)
    reg_idx_t    dst_reg  [N_PROD];
    logic        dst_wr   [N_PROD];
    stage_time_t dst_tnew [N_PROD];

    logic [N_SRC-1:0] stall_src;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             stall;

    logic             md_busy;
    logic             md_done;
    md_cnt_t          md_cnt;

    assign src_reg[0]  = D_rs;
    assign src_reg[1]  = D_rt;
    assign src_tuse[0] = D_Tuse_rs;
    assign src_tuse[1] = D_Tuse_rt;

    assign dst_reg[0]  = E_RFA3;
    assign dst_reg[1]  = M_RFA3;
    assign dst_wr[0]   = E_RFWr;
    assign dst_wr[1]   = M_RFWr;
    assign dst_tnew[0] = E_Tnew;
    assign dst_tnew[1] = M_Tnew;

    // Each operand stalls if any downstream producer is a pending hazard
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            logic [N_PROD-1:0] hit;
            for (genvar gj = 0; gj < N_PROD; gj++) begin : g_prod
                assign hit[gj] = raw_hazard(src_reg[gi], src_tuse[gi],
                                            dst_reg[gj], dst_wr[gj],
                                            dst_tnew[gj]);
            end
            assign stall_src[gi] = |hit;
        end
    endgenerate

    assign stall_rs = stall_src[0];
    assign stall_rt = stall_src[1];

    // MD-class instructions wait while the unit is busy or is being
    // started by the instruction currently in E.
    assign stall_md = D_IsMD && (md_busy || E_MDStart);

    assign stall     = stall_rs || stall_rt || stall_md;
    assign F_PC_En   = !stall;
    assign D_REG_We  = !stall;
    assign E_REG_Clr = stall;

    // Mult/div occupancy runs regardless of pipeline stalls
    md_busy_cnt u_md_busy_cnt (
        .clk   (Clk),
        .srst  (Rst),
        .start (E_MDStart),
        .op    (md_op_e'(E_MDOp)),
        .busy  (md_busy),
        .done  (md_done),
        .cnt   (md_cnt)
    );

    assign MD_Busy = md_busy;
    assign MD_Done = md_done;
    assign MD_Cnt  = md_cnt;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: stimulus pushes the expected outputs for
// each driven cycle into a queue; a monitor on the falling edge pops and
// compares, printing one line per transaction.
module tb_stall_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] D_rs, D_rt;
    logic [1:0] D_Tuse_rs, D_Tuse_rt;
    logic       D_IsMD;
    logic [4:0] E_RFA3, M_RFA3;
    logic       E_RFWr, M_RFWr;
    logic [1:0] E_Tnew, M_Tnew;
    logic       E_MDStart, E_MDOp;
    logic       F_PC_En, D_REG_We, E_REG_Clr;
    logic       MD_Busy, MD_Done;
    logic [3:0] MD_Cnt;

    always #5 Clk = ~Clk;

    stall_ctrl dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_Tuse_rs (D_Tuse_rs),
        .D_Tuse_rt (D_Tuse_rt),
        .D_IsMD    (D_IsMD),
        .E_RFA3    (E_RFA3),
        .M_RFA3    (M_RFA3),
        .E_RFWr    (E_RFWr),
        .M_RFWr    (M_RFWr),
        .E_Tnew    (E_Tnew),
        .M_Tnew    (M_Tnew),
        .E_MDStart (E_MDStart),
        .E_MDOp    (E_MDOp),
        .F_PC_En   (F_PC_En),
        .D_REG_We  (D_REG_We),
        .E_REG_Clr (E_REG_Clr),
        .MD_Busy   (MD_Busy),
        .MD_Done   (MD_Done),
        .MD_Cnt    (MD_Cnt)
    );

    typedef struct {
        string      name;
        logic       stall;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Hand-computed counter tables, index = cycle after the start cycle 0
    logic [3:0] mult_cnt  [7]  = '{4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic [3:0] div_cnt   [12] = '{4'd0, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6,
                                   4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic [3:0] abort_cnt [9]  = '{4'd0, 4'd10, 4'd9, 4'd8, 4'd7,
                                   4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] ovl_cnt   [8]  = '{4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};

    task automatic clear_inputs();
        D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_IsMD = 1'b0;
        E_RFA3 = '0; M_RFA3 = '0; E_RFWr = 1'b0; M_RFWr = 1'b0;
        E_Tnew = '0; M_Tnew = '0; E_MDStart = 1'b0; E_MDOp = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic stall, input logic busy,
                              input logic done, input logic [3:0] cnt);
        exp_t e;
        e.name = name; e.stall = stall; e.busy = busy; e.done = done; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // One hazard-only cycle with the MD unit idle
    task automatic hz(input string name,
                      input logic [4:0] rs, input logic [1:0] trs,
                      input logic [4:0] rt, input logic [1:0] trt,
                      input logic [4:0] ea, input logic ew, input logic [1:0] et,
                      input logic [4:0] ma, input logic mw, input logic [1:0] mt,
                      input logic exp_stall);
        next_cycle();
        clear_inputs();
        D_rs = rs; D_Tuse_rs = trs; D_rt = rt; D_Tuse_rt = trt;
        E_RFA3 = ea; E_RFWr = ew; E_Tnew = et;
        M_RFA3 = ma; M_RFWr = mw; M_Tnew = mt;
        expect_out(name, exp_stall, 1'b0, 1'b0, 4'd0);
    endtask

    // Monitor: compare every cycle that has an expectation queued
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (F_PC_En !== ~e.stall || D_REG_We !== ~e.stall || E_REG_Clr !== e.stall ||
                MD_Busy !== e.busy || MD_Done !== e.done || MD_Cnt !== e.cnt) begin
                tests_failed++;
                $display("FAIL %s: got pc_en=%b dreg_we=%b e_clr=%b busy=%b done=%b cnt=%0d, want pc_en=%b dreg_we=%b e_clr=%b busy=%b done=%b cnt=%0d",
                         e.name, F_PC_En, D_REG_We, E_REG_Clr, MD_Busy, MD_Done, MD_Cnt,
                         ~e.stall, ~e.stall, e.stall, e.busy, e.done, e.cnt);
            end else begin
                $display("ok   %s: stall=%b busy=%b done=%b cnt=%0d",
                         e.name, e.stall, MD_Busy, MD_Done, MD_Cnt);
            end
        end
    end

    initial begin
        Rst = 1'b1;
        clear_inputs();

        // Reset state
        next_cycle();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        next_cycle();
        Rst = 1'b0;

        // Hazard path:          rs  trs  rt  trt  E:a  w  t   M:a  w  t   stall
        hz("rs_E_tnew1_tuse0",   5,  0,   0,  3,   5,   1, 1,  0,   0, 0,  1'b1);
        hz("rs_E_tnew0_tuse0",   5,  0,   0,  3,   5,   1, 0,  0,   0, 0,  1'b0);
        hz("rt_zero_reg",        0,  3,   0,  0,   0,   1, 2,  0,   0, 0,  1'b0);
        hz("rt_M_tnew2_tuse1",   0,  3,   7,  1,   0,   0, 0,  7,   1, 2,  1'b1);
        hz("rs_tuse_none",       9,  3,   0,  3,   9,   1, 2,  0,   0, 0,  1'b0);
        hz("rs_E_nowrite",       5,  0,   0,  3,   5,   0, 2,  0,   0, 0,  1'b0);
        hz("rt_M_tnew_eq_tuse",  0,  3,  12,  2,   0,   0, 0, 12,   1, 2,  1'b0);
        hz("rs_reg_mismatch",    4,  0,   6,  0,   5,   1, 2,  7,   1, 2,  1'b0);
        hz("rs_M_tnew1_tuse0",  31,  0,   0,  3,   0,   0, 0, 31,   1, 1,  1'b1);

        // Mult start at cycle 0: busy 1..5, done at 5, idle at 6
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            clear_inputs();
            E_MDStart = (k == 0);
            E_MDOp    = 1'b0;
            expect_out($sformatf("mult_c%0d", k), 1'b0, mult_cnt[k] != 4'd0,
                       k == 5, mult_cnt[k]);
        end

        // Div start with an MD instruction waiting in D: stalled 0..10
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            clear_inputs();
            D_IsMD    = 1'b1;
            E_MDStart = (k == 0);
            E_MDOp    = 1'b1;
            expect_out($sformatf("div_stall_c%0d", k), k <= 10, div_cnt[k] != 4'd0,
                       k == 10, div_cnt[k]);
        end

        // Div aborted by reset in cycle 4: no done pulse afterwards
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            clear_inputs();
            E_MDStart = (k == 0);
            E_MDOp    = 1'b1;
            Rst       = (k == 4);
            expect_out($sformatf("div_abort_c%0d", k), 1'b0, abort_cnt[k] != 4'd0,
                       1'b0, abort_cnt[k]);
        end
        Rst = 1'b0;

        // Mult with a stray div start at cnt=3 (ignored), single done
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            clear_inputs();
            E_MDStart = (k == 0) || (k == 3);
            E_MDOp    = (k == 3);
            expect_out($sformatf("start_busy_c%0d", k), 1'b0, ovl_cnt[k] != 4'd0,
                       k == 5, ovl_cnt[k]);
        end

        // Start presented in the final busy cycle (cnt=1) is ignored too
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            clear_inputs();
            E_MDStart = (k == 0) || (k == 5);
            E_MDOp    = 1'b0;
            expect_out($sformatf("start_last_c%0d", k), 1'b0, ovl_cnt[k] != 4'd0,
                       k == 5, ovl_cnt[k]);
        end

        // Under reset the hazard path still stalls combinationally
        next_cycle();
        clear_inputs();
        Rst = 1'b1;
        D_rs = 5'd3; D_Tuse_rs = 2'd0; E_RFA3 = 5'd3; E_RFWr = 1'b1; E_Tnew = 2'd2;
        expect_out("rst_hazard", 1'b1, 1'b0, 1'b0, 4'd0);
        next_cycle();
        clear_inputs();
        D_IsMD = 1'b1; E_MDStart = 1'b1;
        expect_out("rst_md_start", 1'b1, 1'b0, 1'b0, 4'd0);
        next_cycle();
        clear_inputs();
        expect_out("rst_start_dropped", 1'b0, 1'b0, 1'b0, 4'd0);
        next_cycle();
        clear_inputs();
        Rst = 1'b0;
        expect_out("rst_release", 1'b0, 1'b0, 1'b0, 4'd0);

        // Let the monitor drain the scoreboard
        repeat (3) @(posedge Clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
